// File: rtl/fof_pkg.sv
// Shared constants for the front-panel button logic: FSM encoding and
// default timing derived from the system clock rate.
package fof_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DOWN = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    localparam int CLK_HZ = 100000000;

    // 10 ms debounce window and 1 s long-press threshold at CLK_HZ
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/button_press_decoder_if.sv
// Button pin and decoded event bundle. The decoder is the slave; the
// consumer of the events (and driver of the pin) is the master.
interface button_press_decoder_if;

    logic btn_in;
    logic btn_level;
    logic press_start;
    logic short_press;
    logic long_press;

    modport slave (
        input  btn_in,
        output btn_level,
        output press_start,
        output short_press,
        output long_press
    );

    modport master (
        output btn_in,
        input  btn_level,
        input  press_start,
        input  short_press,
        input  long_press
    );

endinterface

// File: rtl/button_press_decoder_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous board pins; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/button_press_decoder.sv
// Pushbutton front end: synchronise, debounce, then classify each press as
// short (released early) or long (held to threshold) with one-cycle pulses.
module button_press_decoder
    import fof_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter bit ACTIVE_HIGH     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    button_press_decoder_if.slave btn
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("button_press_decoder: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

    logic sync_q;
    logic sample;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn.btn_in),
        .q   (sync_q)
    );

    assign sample = ACTIVE_HIGH ? sync_q : ~sync_q;

    // Debounce: level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
    logic [DEB_W-1:0] deb_cnt;
    logic             level_q;
    logic             differ;
    logic             deb_toggle;
    logic             level_rise;
    logic             level_fall;

    assign differ     = (sample != level_q);
    assign deb_toggle = differ && (deb_cnt == DEB_MAX);
    assign level_rise = deb_toggle && !level_q;
    assign level_fall = deb_toggle && level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            level_q <= 1'b0;
        end else if (!differ) begin
            deb_cnt <= '0;
        end else if (deb_toggle) begin
            deb_cnt <= '0;
            level_q <= ~level_q;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Press-duration FSM, driven by the same-edge level transitions
    logic [1:0]        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              press_start_q;
    logic              short_press_q;
    logic              long_press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            press_start_q <= 1'b0;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
        end else begin
            press_start_q <= 1'b0;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_rise) begin
                        state         <= DOWN;
                        hold_cnt      <= '0;
                        press_start_q <= 1'b1;
                    end
                end
                DOWN: begin
                    // Release takes priority over reaching the long threshold
                    if (level_fall) begin
                        state         <= IDLE;
                        short_press_q <= 1'b1;
                    end else if (hold_cnt == HOLD_MAX) begin
                        state        <= HELD;
                        long_press_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (level_fall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.press_start = press_start_q;
    assign btn.short_press = short_press_q;
    assign btn.long_press  = long_press_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with short debounce/long windows.
module tb_button_press_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    button_press_decoder_if bus ();

    button_press_decoder #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_HIGH     (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus pattern: pat[k] is sampled by posedge k+1; observation i follows posedge i
    logic pat[$];
    int   rise_at, fall_at, ps_n, ps_at, sp_n, sp_at, lp_n, lp_at;
    bit   mutex_bad;

    task automatic record(input int n);
        logic prev;
        prev      = bus.btn_level;
        rise_at   = -1;
        fall_at   = -1;
        ps_n      = 0;
        ps_at     = -1;
        sp_n      = 0;
        sp_at     = -1;
        lp_n      = 0;
        lp_at     = -1;
        mutex_bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.btn_in = (i < pat.size()) ? pat[i] : 1'b0;
            @(negedge clk);
            if (!prev && bus.btn_level && rise_at < 0) rise_at = i + 1;
            if (prev && !bus.btn_level && fall_at < 0) fall_at = i + 1;
            prev = bus.btn_level;
            if (bus.press_start) begin ps_n++; ps_at = i + 1; end
            if (bus.short_press) begin sp_n++; sp_at = i + 1; end
            if (bus.long_press)  begin lp_n++; lp_at = i + 1; end
            if (int'(bus.press_start) + int'(bus.short_press) + int'(bus.long_press) > 1)
                mutex_bad = 1'b1;
        end
    endtask

    task automatic test_reset();
        int high_cycles;
        rst        = 1'b1;
        bus.btn_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.btn_level, bus.press_start, bus.short_press, bus.long_press} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bus.btn_level, bus.press_start, bus.short_press, bus.long_press});
        end
        rst = 1'b0;
        high_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({bus.btn_level, bus.press_start, bus.short_press, bus.long_press} !== 4'b0000)
                high_cycles++;
        end
        checks++;
        if (high_cycles !== 0) begin
            errors++;
            $display("FAIL reset_idle: outputs high in %0d cycles, expected 0", high_cycles);
        end
    endtask

    task automatic test_short_press();
        pat.delete();
        repeat (10) pat.push_back(1'b1);
        record(30);
        checks++; if (rise_at !== 6) begin errors++; $display("FAIL short_rise_at: got %0d expected 6", rise_at); end
        checks++; if (ps_n !== 1)    begin errors++; $display("FAIL short_ps_count: got %0d expected 1", ps_n); end
        checks++; if (ps_at !== 6)   begin errors++; $display("FAIL short_ps_at: got %0d expected 6", ps_at); end
        checks++; if (sp_n !== 1)    begin errors++; $display("FAIL short_sp_count: got %0d expected 1", sp_n); end
        checks++; if (sp_at !== 16)  begin errors++; $display("FAIL short_sp_at: got %0d expected 16", sp_at); end
        checks++; if (fall_at !== 16) begin errors++; $display("FAIL short_fall_at: got %0d expected 16", fall_at); end
        checks++; if (lp_n !== 0)    begin errors++; $display("FAIL short_lp_count: got %0d expected 0", lp_n); end
        checks++; if (mutex_bad !== 1'b0) begin errors++; $display("FAIL short_mutex: got %0b expected 0", mutex_bad); end
    endtask

    task automatic test_glitch();
        pat.delete();
        repeat (3) pat.push_back(1'b1);
        record(20);
        checks++; if (rise_at !== -1) begin errors++; $display("FAIL glitch_rise: got %0d expected -1", rise_at); end
        checks++; if (ps_n !== 0) begin errors++; $display("FAIL glitch_ps: got %0d expected 0", ps_n); end
        checks++; if (sp_n !== 0) begin errors++; $display("FAIL glitch_sp: got %0d expected 0", sp_n); end
        checks++; if (lp_n !== 0) begin errors++; $display("FAIL glitch_lp: got %0d expected 0", lp_n); end
    endtask

    task automatic test_long_press();
        pat.delete();
        repeat (40) pat.push_back(1'b1);
        record(70);
        checks++; if (ps_at !== 6)   begin errors++; $display("FAIL long_ps_at: got %0d expected 6", ps_at); end
        checks++; if (lp_n !== 1)    begin errors++; $display("FAIL long_lp_count: got %0d expected 1", lp_n); end
        checks++; if (lp_at !== 26)  begin errors++; $display("FAIL long_lp_at: got %0d expected 26", lp_at); end
        checks++; if (sp_n !== 0)    begin errors++; $display("FAIL long_sp_count: got %0d expected 0", sp_n); end
        checks++; if (fall_at !== 46) begin errors++; $display("FAIL long_fall_at: got %0d expected 46", fall_at); end
        checks++; if (mutex_bad !== 1'b0) begin errors++; $display("FAIL long_mutex: got %0b expected 0", mutex_bad); end
    endtask

    task automatic test_bounce();
        pat.delete();
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        pat.push_back(1'b1);
        pat.push_back(1'b0);
        repeat (10) pat.push_back(1'b1);
        record(30);
        checks++; if (ps_n !== 1)   begin errors++; $display("FAIL bounce_ps_count: got %0d expected 1", ps_n); end
        checks++; if (ps_at !== 10) begin errors++; $display("FAIL bounce_ps_at: got %0d expected 10", ps_at); end
        checks++; if (sp_at !== 20) begin errors++; $display("FAIL bounce_sp_at: got %0d expected 20", sp_at); end
    endtask

    task automatic test_reset_mid_press();
        int ps_cnt, lp_cnt, sp_cnt, rise2, ps2, lp2;
        logic prev;
        ps_cnt = 0; lp_cnt = 0; sp_cnt = 0;
        rise2 = -1; ps2 = -1; lp2 = -1;
        prev = bus.btn_level;
        for (int i = 0; i < 70; i++) begin
            bus.btn_in = (i < 50) ? 1'b1 : 1'b0;
            rst        = (i == 16);
            @(negedge clk);
            if (i + 1 == 17) begin
                checks++;
                if ({bus.btn_level, bus.press_start, bus.short_press, bus.long_press} !== 4'b0000) begin
                    errors++;
                    $display("FAIL midrst_outputs: got %b expected 0000",
                             {bus.btn_level, bus.press_start, bus.short_press, bus.long_press});
                end
            end
            if (i + 1 > 17 && !prev && bus.btn_level && rise2 < 0) rise2 = i + 1;
            prev = bus.btn_level;
            if (bus.press_start) begin ps_cnt++; if (i + 1 > 17) ps2 = i + 1; end
            if (bus.long_press)  begin lp_cnt++; lp2 = i + 1; end
            if (bus.short_press) sp_cnt++;
        end
        rst = 1'b0;
        checks++; if (rise2 !== 23) begin errors++; $display("FAIL midrst_rerise_at: got %0d expected 23", rise2); end
        checks++; if (ps2 !== 23)   begin errors++; $display("FAIL midrst_ps_at: got %0d expected 23", ps2); end
        checks++; if (ps_cnt !== 2) begin errors++; $display("FAIL midrst_ps_count: got %0d expected 2", ps_cnt); end
        checks++; if (lp_cnt !== 1) begin errors++; $display("FAIL midrst_lp_count: got %0d expected 1", lp_cnt); end
        checks++; if (lp2 !== 43)   begin errors++; $display("FAIL midrst_lp_at: got %0d expected 43", lp2); end
        checks++; if (sp_cnt !== 0) begin errors++; $display("FAIL midrst_sp_count: got %0d expected 0", sp_cnt); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.btn_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_short_press();
        test_glitch();
        test_long_press();
        test_bounce();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
